mul_pipe: RTL and testbench

MUL_PIPE -- requirements
Module: mul_pipe

---
 rtl/mul_pkg.sv | 31 +++
 rtl/mul_pp.sv | 61 ++++++
 rtl/mul_pipe.sv | 108 ++++++++++
 tb/tb_mul_pipe.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined integer multiplier: mode encoding,
// pipeline depth and small mode-decode helpers.
package mul_pkg;

  // Product-half / signedness selector carried on the mode port.
  typedef enum logic [1:0] {
    MUL    = 2'b00,  // low half, signedness irrelevant
    MULH   = 2'b01,  // high half, signed x signed
    MULHSU = 2'b10,  // high half, signed x unsigned
    MULHU  = 2'b11   // high half, unsigned x unsigned
  } mul_mode_e;

  // Register stages between acceptance and a valid result.
  localparam int MUL_LAT = 3;

  // First operand is sign-extended for the two modes that treat rs1 as signed.
  function automatic logic a_is_signed(input mul_mode_e m);
    return (m == MULH) || (m == MULHSU);
  endfunction

  // Second operand is signed only for MULH.
  function automatic logic b_is_signed(input mul_mode_e m);
    return (m == MULH);
  endfunction

  // Every mode except MUL returns the upper product half.
  function automatic logic hi_half(input mul_mode_e m);
    return (m != MUL);
  endfunction

endpackage

// File: rtl/mul_pp.sv
// Partial-product stage: splits two (W+1)-bit extended operands at SPLIT into
// an unsigned low slice and a signed high slice and registers the four
// signed cross products.
module mul_pp
  import mul_pkg::*;
#(
  parameter int W     = 32,
  parameter int SPLIT = 18
) (
  input  logic                              CLK,
  input  logic                              RSTN,
  input  logic                              en,
  input  logic [W:0]                        ax,
  input  logic [W:0]                        bx,
  output logic signed [2*SPLIT+1:0]         ll,
  output logic signed [W+1:0]               lh,
  output logic signed [W+1:0]               hl,
  output logic signed [2*(W+1-SPLIT)-1:0]   hh
);

  // Low slice gets a zero sign bit so it multiplies as a non-negative value.
  localparam int LO_W = SPLIT + 1;
  localparam int HI_W = W + 1 - SPLIT;
  localparam int LL_W = 2 * LO_W;
  localparam int XH_W = LO_W + HI_W;
  localparam int HH_W = 2 * HI_W;

  logic signed [LO_W-1:0] a_lo, b_lo;
  logic signed [HI_W-1:0] a_hi, b_hi;
  logic signed [LL_W-1:0] ll_d;
  logic signed [XH_W-1:0] lh_d, hl_d;
  logic signed [HH_W-1:0] hh_d;

  assign a_lo = $signed({1'b0, ax[SPLIT-1:0]});
  assign b_lo = $signed({1'b0, bx[SPLIT-1:0]});
  assign a_hi = $signed(ax[W:SPLIT]);
  assign b_hi = $signed(bx[W:SPLIT]);

  // Operands are widened to the full product width first so each product
  // is exact at its natural size.
  assign ll_d = LL_W'(a_lo) * LL_W'(b_lo);
  assign lh_d = XH_W'(a_lo) * XH_W'(b_hi);
  assign hl_d = XH_W'(a_hi) * XH_W'(b_lo);
  assign hh_d = HH_W'(a_hi) * HH_W'(b_hi);

  // Partial-product register, advancing with the global pipeline enable.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ll <= '0;
      lh <= '0;
      hl <= '0;
      hh <= '0;
    end else if (en) begin
      ll <= ll_d;
      lh <= lh_d;
      hl <= hl_d;
      hh <= hh_d;
    end
  end

endmodule

// File: rtl/mul_pipe.sv
// Three-stage valid/ready multiplier: S1 captures and extends operands,
// S2 (mul_pp) forms four partial products, S3 sums them and selects the
// requested product half into rd. The whole pipe advances on one enable,
// so bubbles travel with it and stalls freeze every stage together.
module mul_pipe
  import mul_pkg::*;
#(
  parameter int W     = 32,
  parameter int SPLIT = 18,
  parameter int TAG_W = 4
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [1:0]       mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     rd,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PW = 2 * W;

  logic                 en;
  logic [MUL_LAT:1]     vld_pipe;   // [1]=S1, [2]=S2, [3]=result
  mul_mode_e            mode_in, mode1, mode2;
  logic [TAG_W-1:0]     tag1, tag2;
  logic [W:0]           a_ext, b_ext, ax1, bx1;

  logic signed [2*SPLIT+1:0]       ll;
  logic signed [W+1:0]             lh, hl;
  logic signed [2*(W+1-SPLIT)-1:0] hh;
  logic [PW-1:0]                   prod;
  logic [W-1:0]                    rd_d;

  // Pipe moves whenever the result slot is empty or being drained.
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe[MUL_LAT];

  assign mode_in = mul_mode_e'(mode);
  assign a_ext   = {a_is_signed(mode_in) & a[W-1], a};
  assign b_ext   = {b_is_signed(mode_in) & b[W-1], b};

  // Valid shift register plus S1 operand/sideband capture.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      vld_pipe <= '0;
      ax1      <= '0;
      bx1      <= '0;
      mode1    <= MUL;
      tag1     <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[MUL_LAT-1:1], in_valid};
      ax1      <= a_ext;
      bx1      <= b_ext;
      mode1    <= mode_in;
      tag1     <= in_tag;
    end
  end

  mul_pp #(.W(W), .SPLIT(SPLIT)) u_pp (
    .CLK  (CLK),
    .RSTN (RSTN),
    .en   (en),
    .ax   (ax1),
    .bx   (bx1),
    .ll   (ll),
    .lh   (lh),
    .hl   (hl),
    .hh   (hh)
  );

  // Sideband follows the partial products through S2.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      mode2 <= MUL;
      tag2  <= '0;
    end else if (en) begin
      mode2 <= mode1;
      tag2  <= tag1;
    end
  end

  // Recombine the partials; everything is sign-extended to 2W and the sum
  // wraps modulo 2^(2W), which is exactly the two's-complement product.
  assign prod = PW'(ll)
              + ((PW'(lh) + PW'(hl)) << SPLIT)
              + (PW'(hh) << (2 * SPLIT));

  assign rd_d = hi_half(mode2) ? prod[PW-1:W] : prod[W-1:0];

  // S3 result register; holds while the consumer stalls.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rd      <= '0;
      out_tag <= '0;
    end else if (en) begin
      rd      <= rd_d;
      out_tag <= tag2;
    end
  end

endmodule

// File: tb/tb_mul_pipe.sv
// Bench for mul_pipe: directed corner products, stall/ordering, reset flush,
// a W=16 instance, and randomized traffic checked by a scoreboard.
module tb_mul_pipe;
  import mul_pkg::*;

  localparam int TW = 4;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [31:0]   a, b, rd;
  logic [1:0]    mode;
  logic [TW-1:0] in_tag, out_tag;

  logic          in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0]   a16, b16, rd16;
  logic [1:0]    mode16;
  logic [TW-1:0] in_tag16, out_tag16;

  always #5 CLK = ~CLK;

  mul_pipe #(.W(32), .SPLIT(18), .TAG_W(TW)) dut (
    .CLK(CLK), .RSTN(RSTN), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .rd(rd), .out_tag(out_tag)
  );

  mul_pipe #(.W(16), .SPLIT(9), .TAG_W(TW)) dut16 (
    .CLK(CLK), .RSTN(RSTN), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .mode(mode16), .in_tag(in_tag16),
    .out_valid(out_valid16), .out_ready(out_ready16), .rd(rd16), .out_tag(out_tag16)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference: extend to 64 bits and let the 64-bit product wrap.
  function automatic logic [31:0] ref_rd(input logic [31:0] x, input logic [31:0] y,
                                         input logic [1:0] m);
    logic [63:0] xe, ye, p;
    xe = (m == 2'b01 || m == 2'b10) ? {{32{x[31]}}, x} : {32'b0, x};
    ye = (m == 2'b01) ? {{32{y[31]}}, y} : {32'b0, y};
    p  = xe * ye;
    return (m == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  typedef struct {
    logic [TW-1:0] tag;
    logic [31:0]   val;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_out = 0;

  // Scoreboard: pop on output transfer, push on input transfer.
  always @(negedge CLK) begin
    if (RSTN) begin
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
        else begin
          mon_e = sb.pop_front();
          chk("sb_rd", rd, mon_e.val);
          chk("sb_tag", out_tag, mon_e.tag);
        end
      end
      if (in_valid && in_ready) sb.push_back('{in_tag, ref_rd(a, b, mode)});
    end
  end

  task automatic wait_accept();
    int n = 0;
    logic acc;
    do begin
      @(negedge CLK); acc = in_ready;
      @(posedge CLK); #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drive(input logic [31:0] ta, input logic [31:0] tb2,
                       input logic [1:0] tm, input logic [TW-1:0] tt);
    a = ta; b = tb2; mode = tm; in_tag = tt; in_valid = 1'b1;
    wait_accept();
  endtask

  // Single op on an idle pipe: checks latency and a constant expected result.
  task automatic one_op(input string nm, input logic [31:0] ta, input logic [31:0] tb2,
                        input logic [1:0] tm, input logic [31:0] exp);
    int lat;
    out_ready = 1'b1;
    drive(ta, tb2, tm, 4'hA);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge CLK); #1; lat++;
    end
    chk({nm, "_lat"}, lat, MUL_LAT);
    chk({nm, "_rd"}, rd, exp);
    @(posedge CLK); #1;
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n0, n, cyc;
    logic acc;

    RSTN = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; mode = '0; in_tag = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = '0; b16 = '0; mode16 = '0; in_tag16 = '0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_rd", rd, 0);
    chk("rst_out_tag", out_tag, 0);
    @(posedge CLK); #1; RSTN = 1'b1;

    // W=16 instance: two back-to-back ops, results on consecutive cycles.
    in_valid16 = 1'b1; a16 = 16'h1234; b16 = 16'h5678; mode16 = 2'b00; in_tag16 = 4'd1;
    @(posedge CLK); #1;
    mode16 = 2'b11; in_tag16 = 4'd2;
    @(posedge CLK); #1;
    in_valid16 = 1'b0;
    @(posedge CLK); #1;
    chk("w16_valid", out_valid16, 1);
    chk("w16_mul", rd16, 16'h0060);
    chk("w16_tag1", out_tag16, 1);
    @(posedge CLK); #1;
    chk("w16_mulhu", rd16, 16'h0626);
    chk("w16_tag2", out_tag16, 2);

    // All-ones operands in every mode, plus the most-negative square.
    one_op("ones_mul",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'h0000_0001);
    one_op("ones_mulhu",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'hFFFF_FFFE);
    one_op("ones_mulh",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'h0000_0000);
    one_op("ones_mulhsu", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'hFFFF_FFFF);
    one_op("min_mulh",    32'h8000_0000, 32'h8000_0000, 2'b01, 32'h4000_0000);
    one_op("min_mul",     32'h8000_0000, 32'h8000_0000, 2'b00, 32'h0000_0000);

    // Back-to-back tags 1..4 with a two-cycle consumer stall.
    out_ready = 1'b1;
    n0 = n_out;
    drive(32'd3, 32'd5, 2'b00, 4'd1);
    drive(32'd7, 32'hFFFF_FFF9, 2'b01, 4'd2);
    drive(32'h1234_5678, 32'h9ABC_DEF0, 2'b10, 4'd3);
    chk("b2b_first_valid", out_valid, 1);
    chk("b2b_first_tag", out_tag, 1);
    out_ready = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; mode = 2'b11; in_tag = 4'd4; in_valid = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      chk("b2b_stall_ready", in_ready, 0);
      chk("b2b_hold_tag", out_tag, 1);
      @(posedge CLK); #1;
    end
    out_ready = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    chk("b2b_count", n_out - n0, 4);
    chk("b2b_sb_empty", sb.size(), 0);

    // Reset with three ops in flight flushes everything.
    drive(32'd11, 32'd12, 2'b00, 4'd5);
    drive(32'd13, 32'd14, 2'b00, 4'd6);
    drive(32'd15, 32'd16, 2'b00, 4'd7);
    in_valid = 1'b0;
    RSTN = 1'b0;
    #1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_rd", rd, 0);
    sb.delete();
    n0 = n_out;
    repeat (3) @(posedge CLK);
    #1; RSTN = 1'b1;
    repeat (8) @(posedge CLK);
    #1;
    chk("flush_no_output", n_out - n0, 0);
    chk("flush_out_valid_after", out_valid, 0);

    // Random traffic with input gaps and output throttling.
    cyc = 0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        out_ready = ($urandom_range(0, 3) != 0);
        @(posedge CLK); #1;
        cyc++;
      end
      a = pick_op(); b = pick_op(); mode = 2'($urandom_range(0, 3));
      in_tag = TW'(i); in_valid = 1'b1;
      n = 0;
      do begin
        out_ready = ($urandom_range(0, 3) != 0);
        @(negedge CLK); acc = in_ready;
        @(posedge CLK); #1;
        n++;
      end while (!acc && n < 200);
      cyc += n;
      if (!acc) begin
        chk("rand_accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    chk("rand_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
